// File: rtl/wdata_ingress.sv
// ---------------------------------------------------------------------------
// wdata_ingress
// Write-domain ingress stage of the async FIFO (clock clk_w).
//
// A valid/ready producer stream passes through a two-entry skid buffer and is
// presented to the write-pointer handler and FIFO memory as w_en/w_data.
// Because of the skid buffer, s_ready comes straight from a flop and has no
// combinational path from full.
//
// The block also synchronises the read-domain Gray pointer into clk_w and
// registers an occupancy level plus an almost-full flag.
//
// Ports:
//   clk_w, arst          write clock, asynchronous active-high reset
//   s_valid/s_data       producer stream in
//   s_ready              registered accept indication to the producer
//   w_en/w_data          write request and payload to the FIFO
//   full                 registered full flag from the write-pointer handler
//   b_wptr               binary write pointer (PTR_WIDTH+1 bits)
//   g_rptr               Gray read pointer from clk_r (asynchronous)
//   g_rptr_sync          g_rptr after a two-flop synchroniser
//   level, almost_full   registered occupancy and level >= AF_THRESH
//   stat_words           accepted-word count, saturating 16 bit
//   stat_stalls          cycles with w_en && full, saturating 16 bit
//
// The two stat ports exist only when WDATA_INGRESS_STATS_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module wdata_ingress #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int AF_THRESH  = 6
) (
    input  logic                  clk_w,
    input  logic                  arst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  w_en,
    output logic [DATA_WIDTH-1:0] w_data,
    input  logic                  full,
    input  logic [PTR_WIDTH:0]    b_wptr,
    input  logic [PTR_WIDTH:0]    g_rptr,
    output logic [PTR_WIDTH:0]    g_rptr_sync,
    output logic [PTR_WIDTH:0]    level,
    output logic                  almost_full
`ifdef WDATA_INGRESS_STATS_EN
    ,
    output logic [15:0]           stat_words,
    output logic [15:0]           stat_stalls
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [PTR_WIDTH:0] AF_C = (PTR_WIDTH+1)'(AF_THRESH);

    // Gray to binary: XOR prefix running from the MSB downwards.
    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t                  state_r, state_s;
    logic [DATA_WIDTH-1:0]   out_d_r, out_d_s;
    logic [DATA_WIDTH-1:0]   sk_d_r, sk_d_s;
    logic                    s_ready_r, w_en_r;
    logic                    p_acc_s, f_acc_s;
    logic [PTR_WIDTH:0]      sync1_r, sync2_r;
    logic [PTR_WIDTH:0]      b_rptr_sync_s, diff_s;
    logic [PTR_WIDTH:0]      level_r;
    logic                    af_r;

    assign p_acc_s = s_valid && s_ready_r;
    assign f_acc_s = w_en_r && !full;

    // Skid-buffer next state and data steering.
    always_comb begin
        state_s = state_r;
        out_d_s = out_d_r;
        sk_d_s  = sk_d_r;
        case (state_r)
            ST_EMPTY: begin
                if (p_acc_s) begin
                    state_s = ST_ONE;
                    out_d_s = s_data;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (p_acc_s && f_acc_s) begin
                    out_d_s = s_data;
                end else if (p_acc_s) begin
                    state_s = ST_TWO;
                    sk_d_s  = s_data;
                end else if (f_acc_s) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_TWO: begin
                // s_ready is low here, so only the FIFO side can move.
                if (f_acc_s) begin
                    state_s = ST_ONE;
                    out_d_s = sk_d_r;
                end else begin
                    state_s = ST_TWO;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // Skid-buffer state, payload registers and handshake outputs.
    // s_ready and w_en are decoded from the next state so both are flops.
    always_ff @(posedge clk_w or posedge arst) begin
        if (arst) begin
            state_r   <= ST_EMPTY;
            out_d_r   <= '0;
            sk_d_r    <= '0;
            s_ready_r <= 1'b1;
            w_en_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            out_d_r   <= out_d_s;
            sk_d_r    <= sk_d_s;
            s_ready_r <= (state_s != ST_TWO);
            w_en_r    <= (state_s != ST_EMPTY);
        end
    end

    // Two-flop synchroniser for the read pointer, no logic in between.
    always_ff @(posedge clk_w or posedge arst) begin
        if (arst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= g_rptr;
            sync2_r <= sync1_r;
        end
    end

    assign b_rptr_sync_s = gray2bin(sync2_r);
    // Modulo subtraction: the extra pointer bit makes wrap-around come out right.
    assign diff_s        = b_wptr - b_rptr_sync_s;

    // Occupancy and almost-full share one difference so they stay aligned.
    always_ff @(posedge clk_w or posedge arst) begin
        if (arst) begin
            level_r <= '0;
            af_r    <= 1'b0;
        end else begin
            level_r <= diff_s;
            af_r    <= (diff_s >= AF_C);
        end
    end

`ifdef WDATA_INGRESS_STATS_EN
    logic [15:0] stat_words_r, stat_stalls_r;

    // Saturating accept and stall counters.
    always_ff @(posedge clk_w or posedge arst) begin
        if (arst) begin
            stat_words_r  <= 16'd0;
            stat_stalls_r <= 16'd0;
        end else begin
            if (p_acc_s && (stat_words_r != 16'hFFFF)) begin
                stat_words_r <= stat_words_r + 16'd1;
            end
            if (w_en_r && full && (stat_stalls_r != 16'hFFFF)) begin
                stat_stalls_r <= stat_stalls_r + 16'd1;
            end
        end
    end

    assign stat_words  = stat_words_r;
    assign stat_stalls = stat_stalls_r;
`endif

    assign s_ready     = s_ready_r;
    assign w_en        = w_en_r;
    assign w_data      = out_d_r;
    assign g_rptr_sync = sync2_r;
    assign level       = level_r;
    assign almost_full = af_r;

endmodule

// File: tb/tb_wdata_ingress.sv
`timescale 1ns/1ps
module tb_wdata_ingress;

    logic       clk_w = 1'b0;
    logic       arst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       w_en;
    logic [7:0] w_data;
    logic       full;
    logic [3:0] b_wptr;
    logic [3:0] g_rptr;
    logic [3:0] g_rptr_sync;
    logic [3:0] level;
    logic       almost_full;
`ifdef WDATA_INGRESS_STATS_EN
    logic [15:0] stat_words;
    logic [15:0] stat_stalls;
`endif

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [7:0] sb[$];

    always #5 clk_w = ~clk_w;

    wdata_ingress #(.DATA_WIDTH(8), .PTR_WIDTH(3), .AF_THRESH(6)) dut (
        .clk_w(clk_w), .arst(arst),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .w_en(w_en), .w_data(w_data), .full(full),
        .b_wptr(b_wptr), .g_rptr(g_rptr), .g_rptr_sync(g_rptr_sync),
        .level(level), .almost_full(almost_full)
`ifdef WDATA_INGRESS_STATS_EN
        , .stat_words(stat_words), .stat_stalls(stat_stalls)
`endif
    );

    // Record the handshakes the coming edge will take, then advance one cycle.
    task automatic tick();
        logic [7:0] exp;
        if (s_valid && s_ready) sb.push_back(s_data);
        if (w_en && !full) begin
            checks++;
            pops++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_order: got w_data=%h expected no word", w_data);
            end else begin
                exp = sb.pop_front();
                if (w_data !== exp) begin
                    errors++;
                    $display("FAIL sb_order: got w_data=%h expected %h", w_data, exp);
                end
            end
        end
        @(posedge clk_w); #1;
    endtask

    task automatic test_reset();
        @(posedge clk_w); #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b expected 1", s_ready); end
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL rst_w_en: got %b expected 0", w_en); end
        checks++; if (w_data !== 8'h00) begin errors++; $display("FAIL rst_w_data: got %h expected 00", w_data); end
        checks++; if (level !== 4'd0 || almost_full !== 1'b0 || g_rptr_sync !== 4'd0) begin
            errors++; $display("FAIL rst_level: got level=%0d af=%b sync=%h expected 0 0 0", level, almost_full, g_rptr_sync);
        end
        arst = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        full = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i + 1);
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b expected 1 at word %0d", s_ready, i); end
            tick();
            checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL stream_w_en: got %b expected 1 at word %0d", w_en, i); end
        end
        s_valid = 1'b0;
        tick();
        checks++; if (w_en !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL stream_drain: got w_en=%b left=%0d expected 0 0", w_en, sb.size());
        end
    endtask

    task automatic test_backpressure();
        int start;
        start = pops;
        full = 1'b1;
        s_valid = 1'b1; s_data = 8'hA1; tick();
        s_data = 8'hA2; tick();
        s_data = 8'hA3;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", s_ready); end
        tick(); tick();
        checks++; if (w_en !== 1'b1 || w_data !== 8'hA1) begin
            errors++; $display("FAIL bp_hold: got w_en=%b w_data=%h expected 1 a1", w_en, w_data);
        end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold: got %b expected 0", s_ready); end
        full = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (s_valid && s_ready) begin
                tick();
                s_valid = 1'b0;
            end else begin
                tick();
            end
        end
        checks++; if (pops - start != 3 || sb.size() != 0 || s_valid !== 1'b0) begin
            errors++; $display("FAIL bp_count: got %0d words left=%0d expected 3 0", pops - start, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        full = 1'b1;
        s_valid = 1'b1; s_data = 8'hB1; tick();
        s_data = 8'hB2; tick();
        s_valid = 1'b0;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_two: got s_ready=%b expected 0", s_ready); end
        #2 arst = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1 || w_en !== 1'b0 || w_data !== 8'h00) begin
            errors++; $display("FAIL mid_rst: got s_ready=%b w_en=%b w_data=%h expected 1 0 00", s_ready, w_en, w_data);
        end
        sb.delete();
        @(posedge clk_w); #1;
        arst = 1'b0; full = 1'b0;
        s_valid = 1'b1; s_data = 8'h5A;
        tick();
        s_valid = 1'b0;
        checks++; if (w_en !== 1'b1 || w_data !== 8'h5A) begin
            errors++; $display("FAIL mid_first: got w_en=%b w_data=%h expected 1 5a", w_en, w_data);
        end
        tick();
        checks++; if (w_en !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL mid_drain: got w_en=%b left=%0d expected 0 0", w_en, sb.size());
        end
    endtask

    task automatic test_level();
        logic [3:0] wp [5] = '{4'd8, 4'd0, 4'd5, 4'd5, 4'd2};
        logic [3:0] rp [5] = '{4'd0, 4'd8, 4'd0, 4'd5, 4'd15};
        logic [3:0] el [5] = '{4'd8, 4'd8, 4'd5, 4'd0, 4'd3};
        logic       ea [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] rb;
        b_wptr = 4'd1; g_rptr = 4'b1011;
        @(posedge clk_w); #1;
        @(posedge clk_w); #1;
        checks++; if (g_rptr_sync !== 4'b1011 || level !== 4'd1) begin
            errors++; $display("FAIL lvl_sync: got sync=%b level=%0d expected 1011 1", g_rptr_sync, level);
        end
        @(posedge clk_w); #1;
        checks++; if (level !== 4'd4 || almost_full !== 1'b0) begin
            errors++; $display("FAIL lvl_wrap: got level=%0d af=%b expected 4 0", level, almost_full);
        end
        b_wptr = 4'd3;
        @(posedge clk_w); #1;
        checks++; if (level !== 4'd6 || almost_full !== 1'b1) begin
            errors++; $display("FAIL lvl_af: got level=%0d af=%b expected 6 1", level, almost_full);
        end
        for (int i = 0; i < 5; i++) begin
            rb = rp[i];
            b_wptr = wp[i];
            g_rptr = rb ^ (rb >> 1);
            repeat (3) begin @(posedge clk_w); #1; end
            checks++; if (level !== el[i] || almost_full !== ea[i]) begin
                errors++; $display("FAIL lvl_tab%0d: got level=%0d af=%b expected %0d %b", i, level, almost_full, el[i], ea[i]);
            end
        end
    endtask

`ifdef WDATA_INGRESS_STATS_EN
    task automatic test_stats();
        #2 arst = 1'b1; #1;
        checks++; if (stat_words !== 16'd0 || stat_stalls !== 16'd0) begin
            errors++; $display("FAIL st_rst: got %0d %0d expected 0 0", stat_words, stat_stalls);
        end
        sb.delete();
        @(posedge clk_w); #1;
        arst = 1'b0; full = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 8'(8'hC0 + i); tick();
        end
        s_valid = 1'b0;
        full = 1'b1;
        repeat (3) tick();
        full = 1'b0;
        tick();
        checks++; if (stat_words !== 16'd5 || stat_stalls !== 16'd3) begin
            errors++; $display("FAIL st_count: got words=%0d stalls=%0d expected 5 3", stat_words, stat_stalls);
        end
    endtask
`endif

    initial begin
        arst = 1'b1; s_valid = 1'b0; s_data = 8'h00; full = 1'b0;
        b_wptr = 4'd0; g_rptr = 4'd0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_reset_mid();
        test_level();
`ifdef WDATA_INGRESS_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wdata_ingress.md
# wdata_ingress

Write-domain ingress stage for the async FIFO, clocked by `clk_w`. It accepts a valid/ready stream from the producer and presents it as `w_en`/`w_data` to the write-pointer handler and FIFO memory. A two-entry skid buffer lets `s_ready` come straight from a flop. The block also synchronises the read-domain Gray pointer into `clk_w` and derives a registered occupancy level and an almost-full flag.

## Interface
- `DATA_WIDTH`, default 8: payload width.
- `PTR_WIDTH`, default 3: FIFO address width. Pointers are `PTR_WIDTH+1` bits; depth is `2**PTR_WIDTH`.
- `AF_THRESH`, default 6: `almost_full` asserts when level >= this value. Legal range is 1..`2**PTR_WIDTH`.

Ports:
- `clk_w` in 1: write-domain clock.
- `arst` in 1: asynchronous, active-high reset.
- `s_valid` in 1: producer data valid.
- `s_data` in `DATA_WIDTH`: producer payload.
- `s_ready` out 1: block can accept; registered.
- `w_en` out 1: write request to the FIFO.
- `w_data` out `DATA_WIDTH`: write payload.
- `full` in 1: registered full flag from the write-pointer handler.
- `b_wptr` in `PTR_WIDTH+1`: binary write pointer from the write-pointer handler.
- `g_rptr` in `PTR_WIDTH+1`: Gray read pointer; asynchronous, from `clk_r`.
- `g_rptr_sync` out `PTR_WIDTH+1`: `g_rptr` after the 2-flop synchroniser; goes to the write-pointer handler.
- `level` out `PTR_WIDTH+1`: registered FIFO occupancy, 0..`2**PTR_WIDTH`.
- `almost_full` out 1: registered, `level >= AF_THRESH`.
- `stat_words` out 16: accepted-word count. Present only with `WDATA_INGRESS_STATS_EN`.
- `stat_stalls` out 16: stall-cycle count. Present only with `WDATA_INGRESS_STATS_EN`.

## Operation
- Producer accept: `s_valid && s_ready`.
- FIFO accept: `w_en && !full`. The write-pointer handler increments on exactly this condition.
- Skid buffer has an output register (`out_v`, `out_d`) and a skid register (`sk_v`, `sk_d`).
  - `w_en = out_v`, `w_data = out_d`.
  - `s_ready = !sk_v`.
- States and transitions:
  - EMPTY (`out_v=0`, `sk_v=0`):
    - producer accept -> ONE, data loaded into out.
  - ONE (`out_v=1`, `sk_v=0`):
    - producer accept and FIFO accept -> ONE, out takes the new data.
    - producer accept, no FIFO accept -> TWO, new data goes to skid.
    - FIFO accept only -> EMPTY.
  - TWO (`out_v=1`, `sk_v=1`, `s_ready=0`):
    - FIFO accept -> ONE, out takes skid.
    - otherwise hold.
- Ordering is strict FIFO. No word is ever dropped or duplicated.
- `w_data` is stable while `w_en=1` and `full=1`.
- Synchroniser: two flops on `g_rptr`, no logic between them. `g_rptr_sync` is the second flop.
- Level:
  - `b_rptr_sync` = Gray-to-binary of `g_rptr_sync`, computed as an XOR prefix from the MSB down.
  - `level <= b_wptr - b_rptr_sync`, modulo `2**(PTR_WIDTH+1)`.
  - The subtraction wraps naturally. Example, PTR_WIDTH=3: wptr=1, rptr=13 -> level=4.
- `almost_full <= (b_wptr - b_rptr_sync) >= AF_THRESH`, using the same combinational difference so that `level` and `almost_full` stay cycle-aligned.
- Level is pessimistic: it lags the read side by the synchroniser delay and is never an under-estimate of fullness.

## Timing
- Reset (async assert, clears all flops immediately):
  - `out_v=0`, `sk_v=0`, `out_d=0`, `sk_d=0`.
  - `s_ready=1`, `w_en=0`, `w_data=0`.
  - `g_rptr_sync=0`, `level=0`, `almost_full=0`, stats=0.
- Reset asserted mid-transfer discards buffered words. After deassertion, the block is in EMPTY on the next edge.
- Latency from producer accept to `w_en`:
  - 1 cycle when the out register is free or drains in the same cycle.
  - otherwise waits behind older data.
- `s_ready` deasserts the cycle after entering TWO. It reasserts the cycle after the FIFO accepts from TWO.
- `g_rptr` change -> `g_rptr_sync`: 2 `clk_w` edges. -> `level`/`almost_full`: 3 edges.
- `b_wptr` change -> `level`: 1 edge.
- `full` is consumed combinationally and only gates the state update; it has no combinational path to `s_ready`.

## Configuration
- `WDATA_INGRESS_STATS_EN` defined:
  - `stat_words` increments on every producer accept.
  - `stat_stalls` increments on every cycle with `w_en && full`.
  - Both are 16-bit, saturating at 0xFFFF, and cleared by `arst`.
- Undefined: both ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset:
  - assert `arst` mid-stream with data in TWO -> all outputs at reset values while asserted.
  - first word after release appears on `w_data` 1 cycle after its accept.
- Streaming:
  - `s_valid=1` with data 0x01..0x10, `full=0` -> `w_en` continuous from cycle 2, `w_data` 0x01..0x10 in order, `s_ready` never drops.
- Backpressure:
  - hold `full=1` while pushing 0xA1, 0xA2, 0xA3 -> 0xA1 in out, 0xA2 in skid, `s_ready=0`, 0xA3 held by producer.
  - release `full` -> `w_data` 0xA1, 0xA2, 0xA3 with no loss or duplication.
- Level wrap:
  - PTR_WIDTH=3, `b_wptr=1`, `g_rptr`=Gray(13)=0b1011 held stable -> `level=4` after 3 edges, `almost_full=0`.
  - `b_wptr=3` -> `level=6`, `almost_full=1` one edge later.
- Full level:
  - `b_wptr=8`, `g_rptr=0` -> `level=8`.
  - `b_wptr=0`, `g_rptr`=Gray(8)=0b1100 -> `level=8`.
- Stats, with macro defined:
  - 5 accepts plus 3 cycles of `w_en && full` -> `stat_words=5`, `stat_stalls=3`.
  - Preload near 0xFFFF -> both counters saturate at 0xFFFF.
